// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: owner encoding and fixed fetch access code shared by the arbiter files
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;
  localparam logic [2:0] IF_CTRL_WORD = 3'b010;
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: load/store-priority select with fetch starvation override and lock hold
module mem_arb_select
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic             if_req_i,
  input  logic             ls_req_i,
  input  logic             lock_i,
  input  owner_e           held_i,
  input  logic [CNT_W-1:0] starve_cnt_i,
  output owner_e           sel_o
);
  // a locked selection wins; otherwise LS first unless fetch has waited STARVE_MAX grants
  always_comb
    sel_o = lock_i ? held_i :
            ls_req_i ? ((if_req_i && starve_cnt_i == CNT_W'(STARVE_MAX)) ? OWN_IF : OWN_LS) :
            if_req_i ? OWN_IF : OWN_NONE;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch and load/store ports
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int size       = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [size-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [size-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [size-1:0] ls_addr_i,
  input  logic [size-1:0] ls_wdata_i,
  input  logic [2:0]      ls_ctrl_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [size-1:0] ls_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [size-1:0] mem_addr_o,
  output logic [size-1:0] mem_wdata_o,
  output logic [2:0]      mem_ctrl_o,
  input  logic            mem_ready_i,
  input  logic [size-1:0] mem_rdata_i,
  output logic            core_stall_o
);
  owner_e           sel, sel_q, sel_d, rsp_owner_q, rsp_owner_d;
  logic             lock_q, lock_d, rsp_pending_q, rsp_pending_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             if_req, ls_req, accept, is_if, is_ls;

  // requests are masked while reset is held so every output sits at 0
  assign if_req = if_req_i & reset;
  assign ls_req = ls_req_i & reset;

  mem_arb_select #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) u_select (
    .if_req_i     (if_req),
    .ls_req_i     (ls_req),
    .lock_i       (lock_q),
    .held_i       (sel_q),
    .starve_cnt_i (starve_cnt_q),
    .sel_o        (sel)
  );

  // memory mux, grants, read-data routing and stall
  always_comb begin
    is_if        = sel == OWN_IF;
    is_ls        = sel == OWN_LS;
    mem_req_o    = is_if | is_ls;
    accept       = mem_req_o & mem_ready_i;
    if_gnt_o     = accept & is_if;
    ls_gnt_o     = accept & is_ls;
    mem_we_o     = is_ls & ls_we_i;
    mem_addr_o   = is_ls ? ls_addr_i : is_if ? if_addr_i : '0;
    mem_wdata_o  = is_ls ? ls_wdata_i : '0;
    mem_ctrl_o   = is_ls ? ls_ctrl_i : is_if ? IF_CTRL_WORD : 3'b000;
    if_rvalid_o  = rsp_pending_q & (rsp_owner_q == OWN_IF);
    ls_rvalid_o  = rsp_pending_q & (rsp_owner_q == OWN_LS);
    if_rdata_o   = if_rvalid_o ? mem_rdata_i : '0;
    ls_rdata_o   = ls_rvalid_o ? mem_rdata_i : '0;
    core_stall_o = (if_req & ~if_gnt_o) | (ls_req & ~ls_gnt_o);
  end

  // next-state: lock on back-pressure, read response pipe, starvation count
  always_comb begin
    lock_d        = mem_req_o & ~mem_ready_i;
    sel_d         = sel;
    rsp_pending_d = accept & ~mem_we_o;
    rsp_owner_d   = rsp_pending_d ? sel : OWN_NONE;
    starve_cnt_d  = (!if_req || if_gnt_o) ? '0 :
                    (ls_gnt_o && starve_cnt_q != CNT_W'(STARVE_MAX)) ? starve_cnt_q + 1'b1 :
                    starve_cnt_q;
  end

  // state registers; an in-flight read is dropped by reset
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      lock_q        <= 1'b0;
      sel_q         <= OWN_NONE;
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= OWN_NONE;
      starve_cnt_q  <= '0;
    end else begin
      lock_q        <= lock_d;
      sel_q         <= sel_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
      starve_cnt_q  <= starve_cnt_d;
    end

  a_locked_req_held: assert property (@(posedge clk) disable iff (!reset)
    lock_q |-> ((sel_q == OWN_IF) ? if_req_i : ls_req_i));
  a_one_rvalid: assert property (@(posedge clk) disable iff (!reset)
    !(if_rvalid_o && ls_rvalid_o));
endmodule
